// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access pipeline stage: bus widths, ALU op codes,
// write-back constants, FSM states and the load/store op decoder.
package mem_access_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ALU_OP_W   = 8;

    localparam logic                  RST_ENABLE    = 1'b1;
    localparam logic                  WRITE_DISABLE = 1'b0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR  = '0;
    localparam logic [REG_W-1:0]      ZERO_DWORD    = '0;

    localparam logic [ALU_OP_W-1:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [ALU_OP_W-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [ALU_OP_W-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [ALU_OP_W-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [ALU_OP_W-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [ALU_OP_W-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [ALU_OP_W-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [ALU_OP_W-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_BUSY = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    typedef struct packed {
        logic      is_mem;
        logic      is_load;
        logic      sign_ext;
        acc_size_t size;
    } acc_t;

    function automatic acc_t decode_op(input logic [ALU_OP_W-1:0] op);
        acc_t a;
        a = '{is_mem: 1'b1, is_load: 1'b1, sign_ext: 1'b0, size: SZ_WORD};
        case (op)
            EXE_LB_OP:  begin a.sign_ext = 1'b1; a.size = SZ_BYTE; end
            EXE_LBU_OP: a.size = SZ_BYTE;
            EXE_LH_OP:  begin a.sign_ext = 1'b1; a.size = SZ_HALF; end
            EXE_LHU_OP: a.size = SZ_HALF;
            EXE_LW_OP:  a.size = SZ_WORD;
            EXE_SB_OP:  begin a.is_load = 1'b0; a.size = SZ_BYTE; end
            EXE_SH_OP:  begin a.is_load = 1'b0; a.size = SZ_HALF; end
            EXE_SW_OP:  a.is_load = 1'b0;
            default:    begin a.is_mem = 1'b0; a.is_load = 1'b0; end
        endcase
        return a;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational big-endian lane logic: byte-select decode, store-lane replication,
// misalignment detection and load sign/zero extension.
module mem_align
    import mem_access_pkg::*;
(
    input  logic [ALU_OP_W-1:0] aluop,
    input  logic [1:0]          offset,
    input  logic [REG_W-1:0]    store_data,
    input  logic [REG_W-1:0]    load_word,
    output logic                is_mem,
    output logic                is_load,
    output logic                is_store,
    output logic                misaligned,
    output logic [3:0]          sel,
    output logic [REG_W-1:0]    lane_wdata,
    output logic [REG_W-1:0]    load_result
);

    acc_t       acc;
    logic [7:0] byte_lane;
    logic [15:0] half_lane;

    assign acc      = decode_op(aluop);
    assign is_mem   = acc.is_mem;
    assign is_load  = acc.is_mem & acc.is_load;
    assign is_store = acc.is_mem & ~acc.is_load;

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        sel         = 4'b0000;
        misaligned  = 1'b0;
        lane_wdata  = store_data;
        load_result = load_word;
        byte_lane   = 8'h00;
        half_lane   = 16'h0000;

        case (acc.size)
            SZ_BYTE: begin
                sel        = 4'b1000 >> offset;
                lane_wdata = {4{store_data[7:0]}};
                case (offset)
                    2'b00:   byte_lane = load_word[31:24];
                    2'b01:   byte_lane = load_word[23:16];
                    2'b10:   byte_lane = load_word[15:8];
                    default: byte_lane = load_word[7:0];
                endcase
                load_result = {{24{acc.sign_ext & byte_lane[7]}}, byte_lane};
            end
            SZ_HALF: begin
                misaligned  = offset[0];
                sel         = offset[1] ? 4'b0011 : 4'b1100;
                lane_wdata  = {2{store_data[15:0]}};
                half_lane   = offset[1] ? load_word[15:0] : load_word[31:16];
                load_result = {{16{acc.sign_ext & half_lane[15]}}, half_lane};
            end
            default: begin
                misaligned = |offset;
                sel        = 4'b1111;
            end
        endcase

        if (!acc.is_mem) begin
            sel        = 4'b0000;
            misaligned = 1'b0;
        end
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: ALU results pass through, loads/stores run a
// req/ack bus transaction with a timeout while stalling the pipeline.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int TIMEOUT = 255
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [REG_W-1:0]      wdata_i,
    input  logic [ALU_OP_W-1:0]   aluop_i,
    input  logic [REG_W-1:0]      mem_addr_i,
    input  logic [REG_W-1:0]      reg2_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [REG_W-1:0]      wdata_o,
    output logic                  stallreq,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [REG_W-1:0]      dbus_addr,
    output logic [3:0]            dbus_sel,
    output logic [REG_W-1:0]      dbus_wdata,
    input  logic                  dbus_ack,
    input  logic [REG_W-1:0]      dbus_rdata,
    output logic                  excp_adel,
    output logic                  excp_ades,
    output logic                  excp_bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    mem_state_t       state;
    logic [7:0]       tmo_cnt;
    logic [REG_W-1:0] rdata_q;
    logic             err_q;

    logic             is_mem;
    logic             is_load;
    logic             is_store;
    logic             misaligned;
    logic [3:0]       sel;
    logic [REG_W-1:0] lane_wdata;
    logic [REG_W-1:0] load_result;

    mem_align u_align (
        .aluop       (aluop_i),
        .offset      (mem_addr_i[1:0]),
        .store_data  (reg2_i),
        .load_word   (rdata_q),
        .is_mem      (is_mem),
        .is_load     (is_load),
        .is_store    (is_store),
        .misaligned  (misaligned),
        .sel         (sel),
        .lane_wdata  (lane_wdata),
        .load_result (load_result)
    );

    // NOTE: all state and bus registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state      <= MEM_IDLE;
            tmo_cnt    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            dbus_req   <= 1'b0;
            dbus_we    <= 1'b0;
            dbus_addr  <= '0;
            dbus_sel   <= '0;
            dbus_wdata <= '0;
        end else begin
            case (state)
                MEM_IDLE: begin
                    if (is_mem && !misaligned) begin
                        dbus_req   <= 1'b1;
                        dbus_we    <= is_store;
                        dbus_addr  <= {mem_addr_i[REG_W-1:2], 2'b00};
                        dbus_sel   <= sel;
                        dbus_wdata <= lane_wdata;
                        tmo_cnt    <= '0;
                        state      <= MEM_BUSY;
                    end
                end
                MEM_BUSY: begin
                    // Ack wins over timeout when both land in the last wait cycle.
                    if (dbus_ack) begin
                        rdata_q  <= dbus_rdata;
                        dbus_req <= 1'b0;
                        state    <= MEM_DONE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        err_q    <= 1'b1;
                        dbus_req <= 1'b0;
                        state    <= MEM_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: begin
                    err_q <= 1'b0;
                    state <= MEM_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        wd_o      = wd_i;
        wreg_o    = wreg_i;
        wdata_o   = wdata_i;
        stallreq  = 1'b0;
        excp_adel = 1'b0;
        excp_ades = 1'b0;
        excp_bus  = 1'b0;

        if (rst == RST_ENABLE) begin
            wd_o    = NOP_REG_ADDR;
            wreg_o  = WRITE_DISABLE;
            wdata_o = ZERO_DWORD;
        end else if (state == MEM_BUSY) begin
            stallreq = 1'b1;
            wreg_o   = WRITE_DISABLE;
        end else if (state == MEM_DONE) begin
            if (err_q) begin
                excp_bus = 1'b1;
                wreg_o   = WRITE_DISABLE;
            end else if (is_load) begin
                wdata_o = load_result;
            end else if (is_store) begin
                wreg_o = WRITE_DISABLE;
            end
        end else if (is_mem) begin
            wreg_o = WRITE_DISABLE;
            if (misaligned) begin
                excp_adel = is_load;
                excp_ades = is_store;
            end else begin
                stallreq = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Randomized self-checking bench for mem_access against an arithmetic reference
// model of lane selection, extension, alignment and transaction timing.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i;
    logic [7:0]  aluop_i;
    logic [31:0] mem_addr_i;
    logic [31:0] reg2_i;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_sel;
    logic [31:0] dbus_wdata;
    logic        dbus_ack;
    logic [31:0] dbus_rdata;
    logic        excp_adel;
    logic        excp_ades;
    logic        excp_bus;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                                EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

    mem_access #(.TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst        (rst),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .aluop_i    (aluop_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stallreq   (stallreq),
        .dbus_req   (dbus_req),
        .dbus_we    (dbus_we),
        .dbus_addr  (dbus_addr),
        .dbus_sel   (dbus_sel),
        .dbus_wdata (dbus_wdata),
        .dbus_ack   (dbus_ack),
        .dbus_rdata (dbus_rdata),
        .excp_adel  (excp_adel),
        .excp_ades  (excp_ades),
        .excp_bus   (excp_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: an access of n bytes at offset off occupies big-endian lanes off..off+n-1.
    function automatic void model(input logic [7:0] op, input logic [31:0] addr,
                                  input logic [31:0] reg2, input logic [31:0] rdata,
                                  output bit ld, output bit misal, output logic [3:0] esel,
                                  output logic [31:0] ewdat, output logic [31:0] eldat);
        int n;
        int off;
        bit sgn;
        logic [63:0] m;
        logic [63:0] v;
        n = 4; sgn = 1'b0; ld = 1'b1;
        case (op)
            EXE_LB_OP:  begin n = 1; sgn = 1'b1; end
            EXE_LBU_OP: n = 1;
            EXE_LH_OP:  begin n = 2; sgn = 1'b1; end
            EXE_LHU_OP: n = 2;
            EXE_SB_OP:  begin n = 1; ld = 1'b0; end
            EXE_SH_OP:  begin n = 2; ld = 1'b0; end
            EXE_SW_OP:  ld = 1'b0;
            default:    n = 4;
        endcase
        off   = int'(addr[1:0]);
        misal = (off % n) != 0;
        m     = (64'd1 << (8 * n)) - 64'd1;
        esel  = 4'b0000;
        eldat = 32'h0;
        ewdat = 32'h0;
        for (int i = 0; i < 4 / n; i++)
            ewdat = ewdat | 32'(({32'h0, reg2} & m) << (8 * n * i));
        if (!misal) begin
            esel = 4'(((64'd1 << n) - 64'd1) << (4 - n - off));
            v    = ({32'h0, rdata} >> (8 * (4 - n - off))) & m;
            if (sgn && v[8 * n - 1]) v = v | ~m;
            eldat = v[31:0];
        end
    endfunction

    task automatic go_idle();
        @(posedge clk); #1;
        aluop_i  = EXE_NOP_OP;
        dbus_ack = 1'b0;
    endtask

    task automatic run_alu(input logic [7:0] op, input logic [4:0] wd, input logic [31:0] wdat);
        @(posedge clk); #1;
        aluop_i = op; wd_i = wd; wreg_i = 1'b1; wdata_i = wdat;
        mem_addr_i = $urandom; reg2_i = $urandom; dbus_ack = 1'b0;
        @(negedge clk);
        check("alu_wd", wd_o, wd);
        check("alu_wreg", wreg_o, 1);
        check("alu_wdata", wdata_o, wdat);
        check("alu_stall", stallreq, 0);
        check("alu_req", dbus_req, 0);
    endtask

    // ack_at: BUSY cycle index (0-based) carrying the ack, or -1 for none.
    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [31:0] rdata, input int ack_at, input bit spurious);
        bit ld, misal, fin;
        logic [3:0] esel;
        logic [31:0] ewdat, eldat;
        logic [4:0] wd;
        int stall_cnt, req_cnt;
        model(op, addr, reg2, rdata, ld, misal, esel, ewdat, eldat);
        wd = 5'($urandom_range(1, 31));
        @(posedge clk); #1;
        aluop_i = op; mem_addr_i = addr; reg2_i = reg2;
        wd_i = wd; wreg_i = 1'b1; wdata_i = $urandom;
        dbus_ack = spurious; dbus_rdata = ~rdata;
        if (misal) begin
            @(negedge clk);
            check("misal_adel", excp_adel, ld);
            check("misal_ades", excp_ades, !ld);
            check("misal_wreg", wreg_o, 0);
            check("misal_stall", stallreq, 0);
            check("misal_req", dbus_req, 0);
            @(posedge clk); #1;
            dbus_ack = 1'b0;
            @(negedge clk);
            check("misal_req_after", dbus_req, 0);
            go_idle();
            return;
        end
        stall_cnt = 0; req_cnt = 0; fin = 1'b0;
        for (int c = 0; c < TMO + 4 && !fin; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
                dbus_ack   = (ack_at >= 0) && (c == ack_at + 1);
                dbus_rdata = dbus_ack ? rdata : ~rdata;
            end
            @(negedge clk);
            if (stallreq) begin
                stall_cnt++;
                check("stall_excp", {excp_adel, excp_ades, excp_bus}, 0);
                if (dbus_req) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        check("bus_addr", dbus_addr, {addr[31:2], 2'b00});
                        check("bus_sel", dbus_sel, esel);
                        check("bus_we", dbus_we, !ld);
                        if (!ld) check("bus_wdata", dbus_wdata, ewdat);
                    end
                end
            end else begin
                fin = 1'b1;
                check("done_req", dbus_req, 0);
                check("done_bus_err", excp_bus, ack_at < 0);
                check("done_wreg", wreg_o, ld && ack_at >= 0);
                check("done_wd", wd_o, wd);
                if (ld && ack_at >= 0) check("done_wdata", wdata_o, eldat);
            end
        end
        check("done_reached", fin, 1);
        check("stall_cycles", stall_cnt, ack_at >= 0 ? ack_at + 2 : TMO + 1);
        check("req_cycles", req_cnt, ack_at >= 0 ? ack_at + 1 : TMO);
        go_idle();
    endtask

    task automatic run_reset_in_busy();
        @(posedge clk); #1;
        aluop_i = EXE_LW_OP; mem_addr_i = 32'h300; wd_i = 5'd9; wreg_i = 1'b1;
        wdata_i = 32'h5555_AAAA; dbus_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rstbusy_req_before", dbus_req, 1);
        rst = 1'b1;
        #1;
        check("rstbusy_wreg", wreg_o, 0);
        check("rstbusy_wd", wd_o, 0);
        check("rstbusy_wdata", wdata_o, 0);
        check("rstbusy_stall", stallreq, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstbusy_req_after", dbus_req, 0);
        check("rstbusy_idle_stall", stallreq, 1);
        aluop_i = EXE_NOP_OP;
        @(negedge clk);
        check("rstbusy_stay_idle", dbus_req, 0);
    endtask

    initial begin
        logic [7:0] op;
        int r;
        rst = 1'b1; aluop_i = EXE_NOP_OP; wd_i = 5'd7; wreg_i = 1'b1; wdata_i = 32'hCAFE_F00D;
        mem_addr_i = 32'h0; reg2_i = 32'h0; dbus_ack = 1'b0; dbus_rdata = 32'h0;
        @(negedge clk);
        check("rst_wreg", wreg_o, 0);
        check("rst_wd", wd_o, 0);
        check("rst_wdata", wdata_o, 0);
        check("rst_stall", stallreq, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_req", dbus_req, 0);
        check("rst_sel", dbus_sel, 0);
        check("rst_addr", dbus_addr, 0);

        run_alu(8'h25, 5'd3, 32'h1234_5678);
        run_mem(EXE_LW_OP,  32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0);
        run_mem(EXE_LB_OP,  32'h103, 32'h0, 32'h0000_0080, 0, 1'b1);
        run_mem(EXE_LBU_OP, 32'h103, 32'h0, 32'h0000_0080, 1, 1'b0);
        run_mem(EXE_SH_OP,  32'h202, 32'hAAAA_BEEF, 32'h0, 2, 1'b0);
        run_mem(EXE_LW_OP,  32'h101, 32'h0, 32'h0, 0, 1'b0);
        run_mem(EXE_SW_OP,  32'h102, 32'h0, 32'h0, 0, 1'b0);
        run_mem(EXE_LW_OP,  32'h400, 32'h0, 32'h1111_2222, -1, 1'b0);
        run_mem(EXE_LH_OP,  32'h500, 32'h0, 32'h8001_7FFE, TMO - 1, 1'b0);
        run_reset_in_busy();

        for (int i = 0; i < 60; i++) begin
            r = int'($urandom_range(0, 9));
            if (r < 8) begin
                op = mem_ops[r];
                run_mem(op, $urandom, $urandom, $urandom,
                        int'($urandom_range(0, 4)) - 1, 1'($urandom_range(0, 1)));
            end else begin
                run_alu(8'($urandom_range(1, 8'hDF)), 5'($urandom), $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
